// File: rtl/audio_adc_i2s_rx.sv
// I2S capture path for the WM8731 ADC: synchronises the codec-mastered serial bus,
// deserialises left/right words and queues stereo pairs in a show-ahead FIFO.
//
//   state | meaning
//   IDLE  | not aligned; waiting for LRCK 1->0 (start of a left word)
//   SKIP  | LRCK edge seen on the I2S delay bit; next rise carries the MSB
//   SHIFT | shifting data bits MSB first until DATA_WIDTH bits are in
//   HOLD  | word complete; ignoring remaining slot bits until the next LRCK edge

module audio_adc_i2s_rx #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          aud_bclk,
  input  logic                          aud_adclrck,
  input  logic                          aud_adcdat,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_left,
  output logic [DATA_WIDTH-1:0]         out_right,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_err,
  input  logic                          clear_flags
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, HOLD} state_t;

  logic [1:0] bclk_sync;
  logic [1:0] lrck_sync;
  logic [1:0] dat_sync;
  logic       bclk_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
      bclk_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], aud_bclk};
      lrck_sync <= {lrck_sync[0], aud_adclrck};
      dat_sync  <= {dat_sync[0], aud_adcdat};
      bclk_prev <= bclk_sync[1];
    end
  end

  logic                  bclk_rise;
  logic                  lrck_now;
  logic                  dat_now;
  logic                  lrck_prev;
  logic                  lrck_edge;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] word;

  assign bclk_rise = bclk_sync[1] & ~bclk_prev;
  assign lrck_now  = lrck_sync[1];
  assign dat_now   = dat_sync[1];
  assign lrck_edge = lrck_now != lrck_prev;
  assign word      = {shreg[DATA_WIDTH-2:0], dat_now};

  state_t                state;
  logic                  chan;
  logic [CW-1:0]         bitcnt;
  logic [DATA_WIDTH-1:0] left_word;
  logic                  push_req;
  logic [DATA_WIDTH-1:0] push_left;
  logic [DATA_WIDTH-1:0] push_right;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      chan       <= 1'b0;
      bitcnt     <= '0;
      shreg      <= '0;
      left_word  <= '0;
      lrck_prev  <= 1'b0;
      push_req   <= 1'b0;
      push_left  <= '0;
      push_right <= '0;
      frame_err  <= 1'b0;
    end else begin
      push_req <= 1'b0;
      if (clear_flags)
        frame_err <= 1'b0;
      if (bclk_rise)
        lrck_prev <= lrck_now;

      if (!enable) begin
        state <= IDLE;
      end else if (bclk_rise) begin
        case (state)
          IDLE: begin
            if (lrck_prev && !lrck_now) begin
              state <= SKIP;
              chan  <= 1'b0;
            end
          end
          SKIP: begin
            if (lrck_edge) begin
              // short word: drop everything and realign on a left word
              frame_err <= 1'b1;
              chan      <= 1'b0;
              left_word <= '0;
              state     <= lrck_now ? IDLE : SKIP;
            end else begin
              shreg  <= word;
              bitcnt <= CW'(1);
              state  <= SHIFT;
            end
          end
          SHIFT: begin
            if (lrck_edge) begin
              frame_err <= 1'b1;
              chan      <= 1'b0;
              left_word <= '0;
              state     <= lrck_now ? IDLE : SKIP;
            end else begin
              shreg <= word;
              if (bitcnt == LAST_BIT) begin
                if (chan) begin
                  push_req   <= 1'b1;
                  push_left  <= left_word;
                  push_right <= word;
                end else begin
                  left_word <= word;
                end
                state <= HOLD;
              end else begin
                bitcnt <= bitcnt + CW'(1);
              end
            end
          end
          HOLD: begin
            if (lrck_edge) begin
              state <= SKIP;
              chan  <= ~chan;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic [DATA_WIDTH-1:0] mem_l [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  full;
  logic                  pop;
  logic                  wr_en;
  logic                  drop;

  assign full  = fifo_level == FULL_LVL;
  assign pop   = out_valid & out_ready;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign wr_en = push_req & (~full | pop);
  assign drop  = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_l[wr_ptr] <= push_left;
      mem_r[wr_ptr] <= push_right;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + (AW + 1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW + 1)'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (clear_flags)
        overflow <= 1'b0;
      if (drop)
        overflow <= 1'b1;
    end
  end

  assign out_valid = fifo_level != '0;
  assign out_left  = out_valid ? mem_l[rd_ptr] : '0;
  assign out_right = out_valid ? mem_r[rd_ptr] : '0;

endmodule

// File: tb/tb_audio_adc_i2s_rx.sv
// Directed bench for audio_adc_i2s_rx: drives standard I2S frames (MSB on the second
// BCLK rise after an LRCK change) and checks captured pairs, FIFO and sticky flags.
`timescale 1ns/1ps

module tb_audio_adc_i2s_rx;

  localparam int DW   = 24;
  localparam int HALF = 100;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            aud_bclk;
  logic            aud_adclrck;
  logic            aud_adcdat;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_left;
  logic [DW-1:0]   out_right;
  logic [3:0]      fifo_level;
  logic            overflow;
  logic            frame_err;
  logic            clear_flags;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  audio_adc_i2s_rx #(.DATA_WIDTH(DW), .FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .aud_bclk    (aud_bclk),
    .aud_adclrck (aud_adclrck),
    .aud_adcdat  (aud_adcdat),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_left    (out_left),
    .out_right   (out_right),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .frame_err   (frame_err),
    .clear_flags (clear_flags)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one BCLK period: change lrck/dat on the falling edge, hold through the rise
  task automatic send_bit(input logic l, input logic d);
    aud_bclk    = 1'b0;
    aud_adclrck = l;
    aud_adcdat  = d;
    #(HALF);
    aud_bclk = 1'b1;
    #(HALF);
  endtask

  // slot positions from..to; position 0 is the I2S delay bit, 1..DW carry the word
  task automatic send_range(input logic l, input logic [DW-1:0] w, input int from, input int to,
                            input logic fill);
    for (int p = from; p <= to; p++) begin
      if (p >= 1 && p <= DW) begin
        int idx;
        idx = DW - p;
        send_bit(l, w[idx]);
      end else begin
        send_bit(l, fill);
      end
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] lw, input logic [DW-1:0] rw, input int slot,
                            input logic fill);
    send_range(1'b0, lw, 0, slot - 1, fill);
    send_range(1'b1, rw, 0, slot - 1, fill);
  endtask

  // last right bit with precise timing; rise at t. mode 1: latency checks, mode 2: pop with push
  task automatic send_last(input logic d, input int mode);
    aud_bclk   = 1'b0;
    aud_adcdat = d;
    #(HALF);
    aud_bclk = 1'b1;
    #30;
    if (mode == 1) check_val("lat_not_yet", 32'(out_valid), 0);
    if (mode == 2) out_ready = 1'b1;
    #10;
    out_ready = 1'b0;
    if (mode == 1) check_val("lat_valid", 32'(out_valid), 1);
    #(HALF - 40);
  endtask

  task automatic pop_pair(input string tag, input logic [31:0] el, input logic [31:0] er);
    check_val({tag, "_valid"}, 32'(out_valid), 1);
    check_val({tag, "_left"}, 32'(out_left), el);
    check_val({tag, "_right"}, 32'(out_right), er);
    out_ready = 1'b1;
    #10;
    out_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    #10;
    clear_flags = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b1;
    enable      = 1'b1;
    aud_bclk    = 1'b0;
    aud_adclrck = 1'b1;
    aud_adcdat  = 1'b0;
    out_ready   = 1'b0;
    clear_flags = 1'b0;
    #50;
    reset = 1'b0;
    #10;
    check_val("rst_valid", 32'(out_valid), 0);
    check_val("rst_level", 32'(fifo_level), 0);
    check_val("rst_ovf", 32'(overflow), 0);
    check_val("rst_ferr", 32'(frame_err), 0);
    check_val("rst_left", 32'(out_left), 0);
    check_val("rst_right", 32'(out_right), 0);

    // start mid right channel: nothing captured before the first LRCK 1->0
    for (int i = 0; i < 12; i++) send_bit(1'b1, 1'b1);
    check_val("pre_level", 32'(fifo_level), 0);

    // basic frame with exact output latency
    send_range(1'b0, 24'hA5A5A5, 0, 24, 1'b0);
    send_range(1'b1, 24'h5A5A5A, 0, 23, 1'b0);
    send_last(1'b0, 1);
    check_val("f1_level", 32'(fifo_level), 1);
    check_val("f1_ferr", 32'(frame_err), 0);
    pop_pair("f1", 'hA5A5A5, 'h5A5A5A);
    check_val("f1_pop_level", 32'(fifo_level), 0);

    // 32-bit slots, trailing bits and delay bits set to 1
    send_frame(24'h800001, 24'h7FFFFE, 32, 1'b1);
    check_val("slot32_ferr", 32'(frame_err), 0);
    check_val("slot32_level", 32'(fifo_level), 1);
    pop_pair("slot32", 'h800001, 'h7FFFFE);

    // short left word (10 bits) -> frame error, resync on next left
    send_range(1'b0, 24'hFFFFFF, 0, 10, 1'b0);
    send_range(1'b1, 24'h000000, 0, 24, 1'b0);
    check_val("short_l_ferr", 32'(frame_err), 1);
    check_val("short_l_level", 32'(fifo_level), 0);
    send_frame(24'h123456, 24'hFEDCBA, 25, 1'b0);
    check_val("resync_level", 32'(fifo_level), 1);
    pop_pair("resync", 'h123456, 'hFEDCBA);
    pulse_clear();
    check_val("clear_ferr", 32'(frame_err), 0);

    // short right word: held left discarded, the interrupting left starts a new pair
    send_range(1'b0, 24'h111111, 0, 24, 1'b0);
    send_range(1'b1, 24'h999999, 0, 5, 1'b0);
    send_frame(24'h222222, 24'h333333, 25, 1'b0);
    check_val("short_r_ferr", 32'(frame_err), 1);
    check_val("short_r_level", 32'(fifo_level), 1);
    pop_pair("short_r", 'h222222, 'h333333);
    pulse_clear();

    // overflow: 9 frames into 8 entries, then push+pop while full
    for (int i = 1; i <= 9; i++) send_frame(DW'(i), DW'(i + 'h100), 25, 1'b0);
    check_val("ovf_level", 32'(fifo_level), 8);
    check_val("ovf_flag", 32'(overflow), 1);
    check_val("ovf_head", 32'(out_left), 1);
    pulse_clear();
    check_val("ovf_clear", 32'(overflow), 0);
    send_range(1'b0, 24'h00000A, 0, 24, 1'b0);
    send_range(1'b1, 24'h00010A, 0, 23, 1'b0);
    send_last(1'b0, 2);
    check_val("pp_level", 32'(fifo_level), 8);
    check_val("pp_ovf", 32'(overflow), 0);
    for (int i = 2; i <= 8; i++) pop_pair("drain", i, i + 'h100);
    pop_pair("drain_last", 'h00000A, 'h00010A);
    check_val("drain_valid", 32'(out_valid), 0);
    check_val("drain_left", 32'(out_left), 0);

    // reset in the middle of a left word
    send_frame(24'h777777, 24'h888888, 25, 1'b0);
    send_range(1'b0, 24'hAAAAAA, 0, 5, 1'b0);
    send_range(1'b1, 24'h000000, 0, 24, 1'b0);
    send_range(1'b0, 24'hCCCCCC, 0, 12, 1'b0);
    check_val("prerst_ferr", 32'(frame_err), 1);
    check_val("prerst_level", 32'(fifo_level), 1);
    reset = 1'b1;
    #20;
    reset = 1'b0;
    #10;
    check_val("mrst_valid", 32'(out_valid), 0);
    check_val("mrst_level", 32'(fifo_level), 0);
    check_val("mrst_ferr", 32'(frame_err), 0);
    check_val("mrst_ovf", 32'(overflow), 0);
    send_range(1'b0, 24'hCCCCCC, 13, 24, 1'b0);
    send_range(1'b1, 24'h444444, 0, 24, 1'b0);
    check_val("mrst_nopush", 32'(fifo_level), 0);
    send_frame(24'hABCDEF, 24'h135790, 25, 1'b0);
    check_val("mrst_frame_level", 32'(fifo_level), 1);
    pop_pair("mrst_frame", 'hABCDEF, 'h135790);

    // enable dropped mid left word: that frame is lost, the next one is captured
    send_range(1'b0, 24'h555555, 0, 9, 1'b0);
    enable = 1'b0;
    send_range(1'b0, 24'h555555, 10, 24, 1'b0);
    send_range(1'b1, 24'h666666, 0, 4, 1'b0);
    enable = 1'b1;
    send_range(1'b1, 24'h666666, 5, 24, 1'b0);
    check_val("en_nopush", 32'(fifo_level), 0);
    send_frame(24'hC0FFEE, 24'hBEEF01, 25, 1'b0);
    check_val("en_level", 32'(fifo_level), 1);
    pop_pair("en_frame", 'hC0FFEE, 'hBEEF01);
    check_val("final_ferr", 32'(frame_err), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
